muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit that produces the HI/LO register pair consumed by MFHI/MFLO, complementing the single-cycle ALU for the MIPS operations it cannot perform in one cycle. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO requests from the control path through a start/busy/done handshake. It computes products and quotients with a 32-iteration radix-2 engine and holds the results in architectural HI/LO registers.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 have no effect.
- A  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- B  in  32  rt operand: multiplier or divisor.
- busy  out  1  engine running; start is ignored while high.
- done  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch op and the operand magnitudes (signed ops use |A|, |B|).
  - Latch the result-sign flags.
  - Clear the 6-bit iteration counter.
  - Next state is RUN; busy=1.
- IDLE, start=1, op=MTHI: hi<=A at that edge; lo unchanged; no busy, no done. MTLO updates lo in the same way.
- IDLE, start=1, op 110/111: no state change.
- RUN: one iteration per edge, 32 iterations total (counter 0..31). On the 32nd iteration, next state is FIX.
  - Multiply: shift-add on a 64-bit accumulator; bit i of the multiplier adds the multiplicand.
  - Divide: restoring; shift the {remainder, quotient} pair left one bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- FIX:
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the following cycle; busy=0; next state is IDLE.
- Signed multiply: negate the 64-bit product if the signs of A and B differ. Then hi=product[63:32], lo=product[31:0].
- Signed divide:
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero (signed or unsigned): hi=A as latched, lo=32'hFFFF_FFFF, with the same latency as a normal divide.
- Signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- Operands are captured at start; changes on A/B/op while busy have no effect.
- hi/lo hold their values at all times other than the update points above.

## Timing

- Reset values: busy=0, done=0, hi=0, lo=0; state IDLE; counter 0.
- Mult/div latency: start sampled at edge E0.
  - busy=1 after E0.
  - RUN iterations occur at E1..E32; FIX writes at E33.
  - After E33: done=1, busy=0, and the new hi/lo are visible in the same cycle.
  - Total: 33 edges from the start edge to results.
- done lasts one cycle and is deasserted at E34 unless a new operation completes.
- Back-to-back: start may be asserted in the cycle where done=1 (busy=0) and is accepted at that edge.
- MTHI/MTLO: single-edge update, no handshake outputs.
- start with busy=1: ignored and not queued.
- Reset asserted mid-operation (any state):
  - Outputs return immediately, asynchronously, to their reset values.
  - The aborted operation never raises done.
  - After rst is released, the unit is in IDLE.

## Test plan

- MULT A=32'hFFFF_FFFD (-3), B=5: busy high for E1..E33; done after E33; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
- MULTU A=B=32'hFFFF_FFFF: hi=32'hFFFF_FFFE, lo=32'h0000_0001; then DIV -7/2 started in the done cycle gives lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU A=100, B=0: hi=32'h0000_0064, lo=32'hFFFF_FFFF after 33 edges. Then DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- MTHI A=32'h1234 then MTLO A=32'h5678 on consecutive idle cycles: hi=32'h1234 after the first edge, lo=32'h5678 after the second; busy and done stay 0.
- MULT 7*6 started, second start (MTHI A=1) at counter=5, operands changed mid-run: the MTHI is ignored; result is hi=0, lo=42.
- rst pulsed at counter=10 of a DIVU: busy, done, hi, lo=0 immediately; no done pulse afterwards; a new MULTU 3*4 after release gives lo=12.

Source files
------------

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request/response bundle between the control path and the
//                iterative multiply/divide unit.
//                  start  - request strobe (control -> unit)
//                  op     - operation code (control -> unit)
//                  A, B   - rs / rt operands (control -> unit)
//                  busy   - engine running, start ignored (unit -> control)
//                  done   - one-cycle completion pulse (unit -> control)
//                  hi, lo - architectural HI/LO registers (unit -> control)
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv
//  Description : Iterative radix-2 multiply/divide unit holding the MIPS
//                HI/LO register pair. MULT/MULTU/DIV/DIVU take 33 edges from
//                the accepting edge to results; MTHI/MTLO write in one edge.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - muldiv_if.slave (start/op/A/B in, busy/done/hi/lo out)
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    muldiv_if.slave   bus
);
    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;
    localparam logic [5:0] c_LAST_ITER = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;     // negate product / quotient
    logic                 rneg_q, rneg_d;   // negate remainder (dividend sign)
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Operand sign handling at capture time
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.A[WIDTH-1];
    assign w_b_neg  = w_signed & bus.B[WIDTH-1];
    assign w_mag_a  = w_a_neg ? (~bus.A + 1'b1) : bus.A;
    assign w_mag_b  = w_b_neg ? (~bus.B + 1'b1) : bus.B;

    // Multiply step: the low half of acc holds the not-yet-consumed multiplier
    // bits; the add lands in the high half and the whole pair shifts right.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;

    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}. The shifted
    // remainder needs one extra bit since it can reach 2*divisor-1.
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_step;

    assign w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, mag_b_q});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - mag_b_q;
    assign w_div_step = w_ge ? {w_diff,               acc_q[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

    // Original dividend rebuilt from magnitude and sign (divide-by-zero HI)
    logic [WIDTH-1:0]     w_a_orig;
    assign w_a_orig = rneg_q ? (~mag_a_q + 1'b1) : mag_a_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                            is_div_d = bus.op[1];
                            neg_d    = w_a_neg ^ w_b_neg;
                            rneg_d   = w_a_neg;
                            mag_a_d  = w_mag_a;
                            mag_b_d  = w_mag_b;
                            acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                                 : {{WIDTH{1'b0}}, w_mag_b};
                            cnt_d    = 6'd0;
                            busy_d   = 1'b1;
                            state_d  = S_RUN;
                        end
                        c_OP_MTHI: hi_d = bus.A;
                        c_OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? w_div_step : w_mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == c_LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (mag_b_q == {WIDTH{1'b0}}) begin
                        hi_d = w_a_orig;
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        // The 0x8000_0000 / -1 overflow falls out naturally:
                        // the magnitude quotient negates back to 0x8000_0000.
                        lo_d = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1)
                                      : acc_q[WIDTH-1:0];
                        hi_d = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                      : acc_q[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? (~acc_q + 1'b1) : acc_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mag_a_q  <= {WIDTH{1'b0}};
            mag_b_q  <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv
//  Description : Self-checking bench for muldiv: directed vector table plus
//                hand-written back-to-back, ignored-start, MTHI/MTLO and
//                mid-operation reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv;
    localparam logic [2:0] c_MULT  = 3'b000;
    localparam logic [2:0] c_MULTU = 3'b001;
    localparam logic [2:0] c_DIV   = 3'b010;
    localparam logic [2:0] c_DIVU  = 3'b011;
    localparam logic [2:0] c_MTHI  = 3'b100;
    localparam logic [2:0] c_MTLO  = 3'b101;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a mult/div request and let it be sampled at the next edge (E0)
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        chk({tag, " done_after_start"}, 64'(bus.done), 64'd0);
    endtask

    // Count edges until done, with a bounded wait
    task automatic wait_done(input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int exp_lat, input string tag);
        int lat = 0;
        bit busy_bad = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (!bus.busy) busy_bad = 1'b1;
        end
        chk({tag, " latency"},   64'(lat), 64'(exp_lat));
        chk({tag, " busy_held"}, 64'(busy_bad), 64'd0);
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;

        vecs[0] = '{c_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{c_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{c_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[3] = '{c_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[4] = '{c_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[5] = '{c_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{c_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{c_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[8] = '{c_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi",   64'(bus.hi),   64'd0);
        chk("reset lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            launch(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            wait_done(vecs[i].hi, vecs[i].lo, 33, $sformatf("vec%0d", i));
        end

        // Back-to-back: each new start issued in the done cycle
        @(negedge clk);
        launch(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_multu");
        wait_done(32'hFFFF_FFFE, 32'h0000_0001, 33, "b2b_multu");
        launch(c_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "b2b_div");
        wait_done(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "b2b_div");
        launch(c_DIVU, 32'h0000_0064, 32'h0000_0000, "b2b_divu0");
        wait_done(32'h0000_0064, 32'hFFFF_FFFF, 33, "b2b_divu0");
        launch(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "b2b_ovf");
        wait_done(32'h0000_0000, 32'h8000_0000, 33, "b2b_ovf");

        // Start while busy is ignored; operands change mid-run
        @(negedge clk);
        launch(c_MULT, 32'h0000_0007, 32'h0000_0006, "midrun");
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = c_MTHI;
        bus.A     = 32'h0000_0001;
        bus.B     = 32'h0000_0063;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = c_MULT;
        bus.A     = 32'h0000_FFFF;
        bus.B     = 32'h0000_007B;
        wait_done(32'h0000_0000, 32'h0000_002A, 27, "midrun");
        @(posedge clk);
        #1;
        chk("midrun hi_not_queued", 64'(bus.hi), 64'd0);
        chk("midrun busy_after",    64'(bus.busy), 64'd0);
        chk("midrun done_clears",   64'(bus.done), 64'd0);

        // MTHI then MTLO on consecutive edges, then a no-op code
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = c_MTHI;
        bus.A     = 32'h0000_1234;
        @(posedge clk);
        #1;
        chk("mthi hi",   64'(bus.hi),   64'h1234);
        chk("mthi lo",   64'(bus.lo),   64'h2A);
        chk("mthi busy", 64'(bus.busy), 64'd0);
        bus.op = c_MTLO;
        bus.A  = 32'h0000_5678;
        @(posedge clk);
        #1;
        chk("mtlo lo",   64'(bus.lo),   64'h5678);
        chk("mtlo hi",   64'(bus.hi),   64'h1234);
        chk("mtlo done", 64'(bus.done), 64'd0);
        bus.op = 3'b110;
        bus.A  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("op110 hi",   64'(bus.hi),   64'h1234);
        chk("op110 lo",   64'(bus.lo),   64'h5678);
        chk("op110 busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        launch(c_DIVU, 32'h0000_0064, 32'h0000_0007, "rst_divu");
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst busy", 64'(bus.busy), 64'd0);
        chk("async_rst done", 64'(bus.done), 64'd0);
        chk("async_rst hi",   64'(bus.hi),   64'd0);
        chk("async_rst lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done++;
        end
        chk("after_rst idle", 64'(seen_done), 64'd0);
        @(negedge clk);
        launch(c_MULTU, 32'h0000_0003, 32'h0000_0004, "post_rst");
        wait_done(32'h0000_0000, 32'h0000_000C, 33, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
